// File: rtl/cnt_ascii_tx.sv
// Reports a saturated 0-9999 count as four ASCII decimal digits through UART_TX.
// Define CNT_TX_CRLF_EN to append CR LF to every report.
module cnt_ascii_tx #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic [BIN_W-1:0] count,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done
);

`ifdef CNT_TX_CRLF_EN
  localparam int NUM_BYTES = 6;
`else
  localparam int NUM_BYTES = 4;
`endif
  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, CONV, LOAD, WAIT_FREE, START, WAIT_ACK, WAIT_END, FIN
  } state_t;

  state_t      state, state_next;
  logic [29:0] dd;
  logic [3:0]  iter;
  logic [2:0]  idx;
  logic [31:0] count_ext;
  logic [13:0] sat_val;
  logic [7:0]  byte_sel;

  // Double-dabble register: BCD digits in [29:14], remaining binary in [13:0].
  function automatic logic [29:0] dd_step(input logic [29:0] v);
    logic [29:0] t;
    t = v;
    for (int d = 0; d < 4; d++) begin
      if (t[14+4*d +: 4] >= 4'd5)
        t[14+4*d +: 4] = t[14+4*d +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  always_comb begin
    count_ext = 32'(count);
    sat_val   = (count_ext > 32'd9999) ? 14'd9999 : count_ext[13:0];
  end

  always_comb begin
    byte_sel = 8'h30;
    case (idx)
      3'd0: byte_sel = 8'h30 + {4'd0, dd[29:26]};
      3'd1: byte_sel = 8'h30 + {4'd0, dd[25:22]};
      3'd2: byte_sel = 8'h30 + {4'd0, dd[21:18]};
      3'd3: byte_sel = 8'h30 + {4'd0, dd[17:14]};
`ifdef CNT_TX_CRLF_EN
      3'd4: byte_sel = 8'h0D;
      3'd5: byte_sel = 8'h0A;
`endif
      default: byte_sel = 8'h30;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (send) state_next = CONV;
      CONV:      if (iter == 4'd13) state_next = LOAD;
      LOAD:      state_next = WAIT_FREE;
      WAIT_FREE: if (!tx_busy) state_next = START;
      START:     state_next = WAIT_ACK;
      WAIT_ACK:  if (tx_busy) state_next = WAIT_END;
      WAIT_END:  if (!tx_busy) state_next = (idx == LAST_IDX) ? FIN : LOAD;
      FIN:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Outputs are registered from the next state so each is glitch-free and aligned with its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= (state_next == START);
      busy     <= (state_next != IDLE);
      done     <= (state_next == FIN);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dd      <= '0;
      iter    <= '0;
      idx     <= '0;
      tx_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          idx  <= '0;
          iter <= '0;
          if (send) dd <= {16'd0, sat_val};
        end
        CONV: begin
          dd   <= dd_step(dd);
          iter <= iter + 4'd1;
        end
        LOAD: tx_data <= byte_sel;
        WAIT_END: if (!tx_busy && idx != LAST_IDX) idx <= idx + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cnt_ascii_tx.md
# cnt_ascii_tx

Formats a binary counter value as fixed-width ASCII decimal and streams it byte-by-byte into the UART transmitter. It is the return path of the UART counter system: `uart_top` turns received bytes into commands, and this block reports the current 0–9999 count back out over `tx`. It sits between the counter datapath and `UART_TX`, and drives `tx_start`/`tx_data` while monitoring `tx_busy`.

## Interface
- `BIN_W`, default 14: width of `count`.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: reset. One clock; reset is asynchronous and active-low.
- `send` input 1: report request. Sampled high only in IDLE.
- `count` input BIN_W: binary value to report. Latched on an accepted `send`.
- `tx_busy` input 1: busy flag from `UART_TX`.
- `tx_start` output 1: one-cycle start pulse to `UART_TX`.
- `tx_data` output 8: byte for `UART_TX`. Stable from the `tx_start` cycle until `tx_busy` falls.
- `busy` output 1: high from the cycle after `send` is accepted until the cycle after the last byte completes.
- `done` output 1: one-cycle pulse when the report finishes.

## Operation
- States:
  - IDLE
  - CONV: 14-iteration double-dabble, one shift per cycle.
  - LOAD: select the next byte.
  - WAIT_FREE: wait until `tx_busy` is 0.
  - START: pulse `tx_start`.
  - WAIT_ACK: wait until `tx_busy` is 1.
  - WAIT_END: wait until `tx_busy` is 0.
  - FIN: pulse `done`, then go to IDLE.
- IDLE → CONV when `send` is 1. The same edge latches `min(count, 9999)`: values above 9999 saturate to 9999. Bits of `count` above bit 13 are treated as part of the value before saturation.
- CONV → LOAD after exactly 14 cycles, producing 4 BCD digits. Digit order is thousands, hundreds, tens, ones. Leading zeros are always sent.
- Each byte is `8'h30 + digit`.
- LOAD → WAIT_FREE → START → WAIT_ACK → WAIT_END → LOAD for each following byte.
- After the final byte's WAIT_END, go to FIN.
- A byte index counts 0 to N−1, where N is 4 or 6 (see Configuration). It resets to 0 in IDLE.
- `send` is ignored in every state except IDLE; it is neither queued nor latched.
- Changes on `count` after acceptance do not affect the report in progress.

## Timing
- Reset values: `tx_start`=0, `tx_data`=8'h00, `busy`=0, `done`=0; state IDLE; index 0.
- Cycle map, with the accept edge as cycle 0:
  - `busy` is 1 from cycle 1.
  - CONV occupies cycles 1–14.
  - LOAD is at cycle 15.
  - The earliest `tx_start` is cycle 17, when `tx_busy` is already 0.
- `tx_start` is high for exactly one cycle per byte and never while `tx_busy` is 1.
- WAIT_ACK has no timeout. The block relies on `UART_TX` raising `tx_busy` after `tx_start`.
- `done` and the final `busy` are high in the same FIN cycle. `busy` is 0 on the following cycle, and a new `send` is accepted in that cycle.
- Reset asserted mid-report forces all outputs to their reset values immediately (asynchronous). The report is abandoned with no completion. The first `send` after reset release starts a fresh report.

## Configuration
- `CNT_TX_CRLF_EN` defined: each report is 6 bytes, the 4 digits followed by 8'h0D then 8'h0A, and `done` follows the 8'h0A byte.
- `CNT_TX_CRLF_EN` undefined: each report is the 4 digit bytes only, and `done` follows the ones digit.
- No other behaviour differs between the two builds.

## Test plan
- `count`=1234 with `send` pulsed and a UART_TX model in the loop → bytes 0x31, 0x32, 0x33, 0x34, then with the macro 0x0D, 0x0A. Exactly one `done`. `tx_start` pulse count equals the byte count.
- `count`=0 → 0x30, 0x30, 0x30, 0x30. Then `count`=14'd12000 → 0x39, 0x39, 0x39, 0x39 (saturated).
- `send` pulsed again during the second byte, and `count` changed mid-report → the output stream is unchanged, with no extra report and no extra `done`.
- `tx_busy` held at 1 for 50 cycles before the first byte → `tx_start` stays 0 until the cycle after `tx_busy` falls.
- `rst` asserted during the third byte → outputs at reset values within that cycle, no `done`. A following `send` with `count`=42 → 0x30, 0x30, 0x34, 0x32.
- Back-to-back: `send` issued on the cycle after `done` → accepted, and `busy` returns to 1 one cycle later.
